prog_loader: RTL and testbench
==============================

# prog_loader

Program store and serial loader for the PPWM channel. It holds `2**PC_WIDTH` instruction words and serves them combinationally to the execution stage, indexed by that stage's program counter. It also accepts a new program over a one-bit serial strobe interface. While a load is in progress it gates the period-start pulse, so the execution stage never runs a partially written program.

## Interface
- `INSTR_WIDTH`, default 7: instruction word width; must match the execution stage.
- `PC_WIDTH`, default 4: program counter width. Depth is `2**PC_WIDTH` words.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset; asynchronous, active-low.
- `load_i`, input, 1: load-mode request, level sensitive.
- `bit_i`, input, 1: serial program bit, MSB of each word first.
- `bit_valid_i`, input, 1: qualifies `bit_i` for exactly one cycle per bit.
- `start_i`, input, 1: period-start pulse from the timebase.
- `pc_i`, input, `PC_WIDTH`: read address from the execution stage.
- `instr_o`, output, `INSTR_WIDTH`: instruction at `pc_i`.
- `start_o`, output, 1: gated start pulse to the execution stage.
- `loading_o`, output, 1: high while in StLoad.
- `load_done_o`, output, 1: one-cycle pulse after a complete program is written.
- `load_err_o`, output, 1: sticky error flag.

## Operation
- States: StRun (reset) and StLoad.
- **StRun to StLoad:** when `load_i` = 1. On entry, bit counter = 0, word address = 0, shift register = 0, `load_err_o` cleared.
- **Shifting:** in StLoad, each cycle with `bit_valid_i` = 1 shifts `bit_i` into the shift register LSB. Earlier bits move toward the MSB.
- **Word write:**
  - On the bit that completes a word, the full word (including that bit) is written to `mem[addr]`.
  - `addr` increments and the bit counter returns to 0.
  - A write issued at edge N is visible on `instr_o` after edge N.
- **Load completion:**
  - The write to address `2**PC_WIDTH-1` ends the load: the state returns to StRun and `load_done_o` pulses in the following cycle.
  - `addr` wraps to 0; no further words are accepted until the next StLoad entry.
- **Abort:**
  - If `load_i` drops in StLoad before completion, the state returns to StRun.
  - Words already written are kept; the partial word is discarded.
  - `load_err_o` = 1 and `load_done_o` stays 0.
- `bit_valid_i` is ignored in StRun.
- **`instr_o`:** equals `mem[pc_i]` in StRun (combinational, zero latency) and all-zero in StLoad.
- **`start_o`:** equals `start_i` when state = StRun and `load_i` = 0; otherwise 0. No registering.
- **`load_i` held high after completion:** StLoad is re-entered on the next cycle and a fresh load begins at address 0. The host must drop `load_i` within one cycle of `load_done_o`.

## Timing
- **Reset values:**
  - All memory words = 0; state = StRun.
  - `instr_o` = `mem[pc_i]` = 0; `start_o` = `start_i` gated as specified (high only when StRun and `load_i` = 0).
  - `loading_o`, `load_done_o`, `load_err_o` = 0.
- Read latency: 0 cycles, from `pc_i` to `instr_o`.
- `loading_o` rises one cycle after `load_i` is sampled high.
- `start_o` is blocked in the same cycle that `load_i` rises.
- **`start_i` and `load_i` rising in the same cycle:** `start_o` = 0.
- **Reset mid-load:** the memory returns to all-zero immediately and the state returns to StRun.
- **Simultaneous `bit_valid_i` and `load_i` falling edge:** the bit is dropped and the abort is taken.

## Configuration
- `PROG_LOADER_PARITY_EN` defined:
  - Each serial word is `INSTR_WIDTH+1` bits: the data bits MSB first, followed by one even-parity bit.
  - On a parity mismatch the word is not written, `addr` does not advance and `load_err_o` = 1. The load continues, and the host resends that word.
- Undefined: words are `INSTR_WIDTH` bits, no parity check, and `load_err_o` is set only on abort.

## Structure
- `ppwm_pkg` gains:
  - `loader_state_e` (StRun, StLoad);
  - `PROG_DEPTH` constant, derived from the `PC_WIDTH` default.
- One sub-module: `prog_loader_deser`. It contains the shift register, bit counter, word-complete strobe and parity check. It is instantiated once.
- The memory array, address counter and FSM stay in the top module.

## Test plan
- **Reset readback:** assert `rst_n` = 0, release it, sweep `pc_i` over 0..15. Required: `instr_o` = 0 for every address; `start_i` pulse → `start_o` pulse.
- **Full load:** load 16 words `mem[k]` = k·5 mod 128. Required: `load_done_o` for exactly 1 cycle; readback matches; `load_err_o` = 0.
- **Start gating:** hold `load_i` = 1 and pulse `start_i` 3 times. Required: `start_o` = 0 throughout and `instr_o` = 0.
- **Abort:** drop `load_i` after 3 words plus 4 bits. Required:
  - `mem[0..2]` = new words and `mem[3..15]` unchanged;
  - `load_err_o` = 1 and no `load_done_o`.
- **Parity** (with `PROG_LOADER_PARITY_EN`): send word 7'h15 with a wrong parity bit, then resend it with correct parity. Required: `load_err_o` = 1; `mem[0]` = 7'h15; address advances once.
- **Async reset mid-load:** pull `rst_n` low at word 8. Required: outputs reset with no clock edge and all words read 0.

Source files
------------

// File: rtl/ppwm_pkg.sv
// ppwm_pkg: shared types and constants for the PPWM channel.
//   loader_state_e   : program loader FSM states (StRun, StLoad)
//   PROG_PC_WIDTH    : default program counter width
//   PROG_INSTR_WIDTH : default instruction word width
//   PROG_DEPTH       : program store depth for the default PC width
package ppwm_pkg;

    typedef enum logic {
        StRun  = 1'b0,
        StLoad = 1'b1
    } loader_state_e;

    localparam int unsigned PROG_PC_WIDTH    = 4;
    localparam int unsigned PROG_INSTR_WIDTH = 7;
    localparam int unsigned PROG_DEPTH       = 1 << PROG_PC_WIDTH;

endpackage

// File: rtl/prog_loader_deser.sv
// prog_loader_deser: serial-to-parallel word assembler for the program loader.
// Optional feature macro: PROG_LOADER_PARITY_EN (adds a trailing even-parity bit
// to each serial word and checks it).
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear_i      : synchronously empties shift register and bit counter
//   shift_en_i   : a qualified serial bit is present on bit_i
//   bit_i        : serial data, MSB of each word first
//   word_valid_o : the current bit completes a word (combinational strobe)
//   word_o       : assembled word, valid with word_valid_o
//   parity_ok_o  : parity of the completed word is good (always 1 without parity)
module prog_loader_deser
    import ppwm_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = PROG_INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear_i,
    input  logic                   shift_en_i,
    input  logic                   bit_i,
    output logic                   word_valid_o,
    output logic [INSTR_WIDTH-1:0] word_o,
    output logic                   parity_ok_o
);

`ifdef PROG_LOADER_PARITY_EN
    localparam int unsigned WORD_BITS = INSTR_WIDTH + 1;
    // Holds all data bits; the parity bit arrives on bit_i with the strobe.
    localparam int unsigned SHIFT_W   = INSTR_WIDTH;
`else
    localparam int unsigned WORD_BITS = INSTR_WIDTH;
    // The final data bit is taken straight from bit_i, so one bit less is stored.
    localparam int unsigned SHIFT_W   = INSTR_WIDTH - 1;
`endif
    localparam int unsigned CNT_W = $clog2(WORD_BITS + 1);

    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               last_bit;

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        last_bit     = (cnt_q == CNT_W'(WORD_BITS - 1));
        word_valid_o = shift_en_i && last_bit;

        if (clear_i) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_en_i) begin
            shift_d = {shift_q[SHIFT_W-2:0], bit_i};
            cnt_d   = last_bit ? '0 : cnt_q + CNT_W'(1);
        end
    end

`ifdef PROG_LOADER_PARITY_EN
    assign word_o      = shift_q;
    assign parity_ok_o = ~(^shift_q ^ bit_i);
`else
    assign word_o      = {shift_q, bit_i};
    assign parity_ok_o = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: program store and serial loader for the PPWM channel.
// Optional feature macro: PROG_LOADER_PARITY_EN (per-word even parity; a bad
// word is dropped, flagged on load_err_o, and must be resent by the host).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   load_i        : load-mode request (level)
//   bit_i         : serial program bit, MSB first
//   bit_valid_i   : qualifies bit_i for one cycle
//   start_i       : period-start pulse from the timebase
//   pc_i          : read address from the execution stage
//   instr_o       : mem[pc_i] in StRun, zero in StLoad (combinational)
//   start_o       : start_i gated off while loading or load requested
//   loading_o     : high while in StLoad
//   load_done_o   : one-cycle pulse after the last word is written
//   load_err_o    : sticky error (abort or parity), cleared on load entry
module prog_loader
    import ppwm_pkg::*;
#(
    parameter int unsigned INSTR_WIDTH = PROG_INSTR_WIDTH,
    parameter int unsigned PC_WIDTH    = PROG_PC_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load_i,
    input  logic                   bit_i,
    input  logic                   bit_valid_i,
    input  logic                   start_i,
    input  logic [PC_WIDTH-1:0]    pc_i,
    output logic [INSTR_WIDTH-1:0] instr_o,
    output logic                   start_o,
    output logic                   loading_o,
    output logic                   load_done_o,
    output logic                   load_err_o
);

    localparam int unsigned DEPTH = 1 << PC_WIDTH;

    loader_state_e          state_q, state_d;
    logic [PC_WIDTH-1:0]    addr_q, addr_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0] mem_d [DEPTH];

    logic                   deser_clear;
    logic                   deser_shift;
    logic                   word_valid;
    logic [INSTR_WIDTH-1:0] word;
    logic                   parity_ok;

    // Deserializer is held empty whenever not loading, so every load and
    // every abort starts from a clean word boundary.
    assign deser_clear = (state_q == StRun);
    // A bit arriving together with the load_i falling edge is dropped.
    assign deser_shift = (state_q == StLoad) && load_i && bit_valid_i;

    prog_loader_deser #(
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_deser (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (deser_clear),
        .shift_en_i  (deser_shift),
        .bit_i       (bit_i),
        .word_valid_o(word_valid),
        .word_o      (word),
        .parity_ok_o (parity_ok)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        done_d  = 1'b0;
        err_d   = err_q;
        mem_d   = mem_q;

        unique case (state_q)
            StRun: begin
                if (load_i) begin
                    state_d = StLoad;
                    addr_d  = '0;
                    err_d   = 1'b0;
                end
            end
            StLoad: begin
                if (!load_i) begin
                    state_d = StRun;
                    err_d   = 1'b1;
                end else if (word_valid) begin
                    if (parity_ok) begin
                        mem_d[addr_q] = word;
                        addr_d        = addr_q + PC_WIDTH'(1);
                        if (&addr_q) begin
                            state_d = StRun;
                            done_d  = 1'b1;
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StRun;
            addr_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            err_q   <= err_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign loading_o   = (state_q == StLoad);
    assign instr_o     = (state_q == StLoad) ? '0 : mem_q[pc_i];
    assign start_o     = start_i && (state_q == StRun) && !load_i;
    assign load_done_o = done_q;
    assign load_err_o  = err_q;

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    localparam int W     = 7;
    localparam int PCW   = 4;
    localparam int DEPTH = 16;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           load_i;
    logic           bit_i;
    logic           bit_valid_i;
    logic           start_i;
    logic [PCW-1:0] pc_i;
    logic [W-1:0]   instr_o;
    logic           start_o;
    logic           loading_o;
    logic           load_done_o;
    logic           load_err_o;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    // Reference program store: what the channel should hold after each step.
    logic [W-1:0] ref_mem [DEPTH];

    prog_loader #(
        .INSTR_WIDTH(W),
        .PC_WIDTH   (PCW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_i),
        .bit_i      (bit_i),
        .bit_valid_i(bit_valid_i),
        .start_i    (start_i),
        .pc_i       (pc_i),
        .instr_o    (instr_o),
        .start_o    (start_o),
        .loading_o  (loading_o),
        .load_done_o(load_done_o),
        .load_err_o (load_err_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (load_done_o === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bit_i       = b;
        bit_valid_i = 1'b1;
        tick();
        bit_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input logic bad_parity);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
`ifdef PROG_LOADER_PARITY_EN
        send_bit((^w) ^ bad_parity);
`else
        if (bad_parity) $display("note: parity not configured");
`endif
    endtask

    task automatic readback(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            pc_i = PCW'(k);
            #1;
            check(tag, 32'(instr_o), 32'(ref_mem[k]));
        end
    endtask

    task automatic enter_load();
        load_i  = 1'b1;
        start_i = 1'b1;
        #1;
        check("start_blocked_on_load_rise", 32'(start_o), 32'd0);
        start_i = 1'b0;
        tick();
        check("loading_rises", 32'(loading_o), 32'd1);
        check("err_cleared_on_entry", 32'(load_err_o), 32'd0);
    endtask

    initial begin
        logic [W-1:0] w;
        int           d0;

        rst_n = 1'b0; load_i = 1'b0; bit_i = 1'b0; bit_valid_i = 1'b0;
        start_i = 1'b0; pc_i = '0;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        #12;
        check("reset_loading", 32'(loading_o), 32'd0);
        check("reset_done", 32'(load_done_o), 32'd0);
        check("reset_err", 32'(load_err_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Reset readback and start pass-through.
        readback("reset_readback");
        start_i = 1'b1; #1;
        check("start_passthrough", 32'(start_o), 32'd1);
        start_i = 1'b0; #1;
        check("start_passthrough_low", 32'(start_o), 32'd0);
        tick();

        // Full load: mem[k] = k*5 mod 128.
        d0 = done_cnt;
        enter_load();
        pc_i = 4'd3; #1;
        check("instr_zero_loading", 32'(instr_o), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            w = W'((k * 5) % 128);
            ref_mem[k] = w;
            send_word(w, 1'b0);
            if (k < DEPTH - 1) check("no_early_done", 32'(load_done_o), 32'd0);
        end
        check("done_pulse", 32'(load_done_o), 32'd1);
        check("loading_falls_on_done", 32'(loading_o), 32'd0);
        load_i = 1'b0;
        tick();
        check("done_one_cycle", 32'(load_done_o), 32'd0);
        check("done_count_full", 32'(done_cnt - d0), 32'd1);
        check("err_after_full", 32'(load_err_o), 32'd0);
        readback("full_readback");
        // Random-order reads with zero latency.
        for (int n = 0; n < 8; n++) begin
            int a;
            a = int'($urandom_range(DEPTH - 1, 0));
            pc_i = PCW'(a);
            #1;
            check("random_read", 32'(instr_o), 32'(ref_mem[a]));
        end

        // Start gating while load_i held high.
        enter_load();
        for (int n = 0; n < 3; n++) begin
            start_i = 1'b1; pc_i = PCW'(n + 1); #1;
            check("start_gated", 32'(start_o), 32'd0);
            check("instr_gated", 32'(instr_o), 32'd0);
            start_i = 1'b0;
            tick();
        end
        load_i = 1'b0;
        tick();
        check("gating_abort_err", 32'(load_err_o), 32'd1);
        readback("gating_keeps_mem");

        // Abort after 3 random words + 4 bits; last bit coincides with load_i fall.
        d0 = done_cnt;
        enter_load();
        for (int k = 0; k < 3; k++) begin
            w = W'($urandom);
            ref_mem[k] = w;
            send_word(w, 1'b0);
        end
        for (int n = 0; n < 3; n++) send_bit(1'($urandom));
        bit_i = 1'b1; bit_valid_i = 1'b1; load_i = 1'b0;
        tick();
        bit_valid_i = 1'b0;
        check("abort_loading", 32'(loading_o), 32'd0);
        check("abort_err", 32'(load_err_o), 32'd1);
        tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        readback("abort_readback");

`ifdef PROG_LOADER_PARITY_EN
        // Bad parity word is dropped, resend lands at the same address.
        enter_load();
        send_word(7'h15, 1'b1);
        check("parity_err", 32'(load_err_o), 32'd1);
        check("parity_still_loading", 32'(loading_o), 32'd1);
        send_word(7'h15, 1'b0);
        ref_mem[0] = 7'h15;
        load_i = 1'b0;
        tick();
        check("parity_err_sticky", 32'(load_err_o), 32'd1);
        readback("parity_readback");
`endif

        // Asynchronous reset in the middle of word 8.
        enter_load();
        for (int k = 0; k < 8; k++) send_word(W'($urandom), 1'b0);
        send_bit(1'b1); send_bit(1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < DEPTH; k++) ref_mem[k] = '0;
        check("areset_loading", 32'(loading_o), 32'd0);
        check("areset_done", 32'(load_done_o), 32'd0);
        check("areset_err", 32'(load_err_o), 32'd0);
        load_i = 1'b0;
        readback("areset_readback");
        tick();
        rst_n = 1'b1;
        tick();
        readback("post_reset_readback");
        start_i = 1'b1; #1;
        check("post_reset_start", 32'(start_o), 32'd1);
        start_i = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
